regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the write-data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, meaning the register-address width (2**ADDR_WIDTH registers).
REQ-003 The block SHALL have port clock  input  1  system clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port alu_valid  input  1  ALU writeback request.
REQ-006 The block SHALL have port alu_addr  input  ADDR_WIDTH  ALU destination register.
REQ-007 The block SHALL have port alu_data  input  DATA_WIDTH  ALU result.
REQ-008 The block SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-009 The block SHALL have ports mem_valid, mem_addr, mem_data and mem_ready, with the same widths and roles as the alu_* ports, for the load-unit requester.
REQ-010 The block SHALL have port issue_valid  input  1  an instruction with a destination is issued.
REQ-011 The block SHALL have port issue_addr  input  ADDR_WIDTH  destination of the issued instruction.
REQ-012 The block SHALL have port rf_write_enable  output  1  register-file write enable.
REQ-013 The block SHALL have port rf_write_address  output  ADDR_WIDTH  register-file write address.
REQ-014 The block SHALL have port rf_write_data  output  DATA_WIDTH  register-file write data.
REQ-015 The block SHALL have port pending  output  2**ADDR_WIDTH  per-register write-pending scoreboard.
REQ-016 The block SHALL have port last_grant  output  1  last accepted requester (0 = ALU, 1 = MEM).

Function
REQ-017 A transfer SHALL occur on a rising edge where valid and ready are both 1 for that requester.
REQ-018 alu_ready and mem_ready SHALL be combinational from the valids and last_grant; at most one SHALL be 1 in any cycle.
REQ-019 With only one valid asserted, that requester SHALL receive ready.
REQ-020 With both valids asserted, the requester not named by last_grant SHALL receive ready (round-robin).
REQ-021 last_grant SHALL update to the granted requester on every transfer and SHALL hold otherwise.
REQ-022 A transfer at edge N SHALL drive rf_write_enable=1, rf_write_address=addr and rf_write_data=data from edge N until edge N+1 (one-cycle latency, one-cycle pulse).
REQ-023 rf_write_enable SHALL be 0 in every cycle not following a transfer; address and data SHALL hold their last values.
REQ-024 A transfer to address 0 SHALL be accepted (ready asserted, last_grant updated) but SHALL NOT assert rf_write_enable.
REQ-025 issue_valid=1 with issue_addr!=0 SHALL set pending[issue_addr] at the edge.
REQ-026 issue_valid with issue_addr=0 SHALL be ignored; pending[0] SHALL always be 0.
REQ-027 A transfer SHALL clear pending[addr] at the transfer edge.
REQ-028 A set and a clear of the same pending bit at the same edge SHALL leave the bit at 1 (set wins).
REQ-029 A transfer to a register whose pending bit is 0 SHALL still be performed normally.

Reset
REQ-030 While reset=0, outputs SHALL be rf_write_enable=0, rf_write_address=0, rf_write_data=0, pending=0 and last_grant=1, regardless of clock.
REQ-031 Ready outputs SHALL be 0 while reset=0, and a write captured before reset assertion SHALL be discarded.
REQ-032 The first contended cycle after reset deassertion SHALL grant the ALU.

Verification
REQ-033 Reset, then alu_valid=1, alu_addr=3, alu_data=8'h5A for one cycle -> alu_ready=1; the next cycle rf_write_enable=1, rf_write_address=3, rf_write_data=8'h5A; enable=0 the cycle after.
REQ-034 Both valids held for 4 cycles (ALU addr 1/8'h11, MEM addr 2/8'h22) -> grants ALU, MEM, ALU, MEM; writes to 1, 2, 1, 2 each one cycle later.
REQ-035 MEM transfer to addr 0 with data 8'hFF -> mem_ready=1 and last_grant=1, with rf_write_enable staying 0.
REQ-036 issue addr 5, then the same cycle as an ALU transfer to 5, issue 5 again -> pending[5]=1 after the first edge and still 1 after the second edge; a later transfer to 5 clears it.
REQ-037 Assert reset mid-transfer (edge after ALU accept) -> rf_write_enable, pending and rf_write_* become 0 immediately, last_grant=1, and no write appears after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter between the ALU and the load unit, feeding a
// single register-file write port and tracking outstanding writes per register.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         alu_valid,
  input  logic [ADDR_WIDTH-1:0]        alu_addr,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  output logic                         alu_ready,
  input  logic                         mem_valid,
  input  logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  output logic                         mem_ready,
  input  logic                         issue_valid,
  input  logic [ADDR_WIDTH-1:0]        issue_addr,
  output logic                         rf_write_enable,
  output logic [ADDR_WIDTH-1:0]        rf_write_address,
  output logic [DATA_WIDTH-1:0]        rf_write_data,
  output logic [(2**ADDR_WIDTH)-1:0]   pending,
  output logic                         last_grant
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REGS-1:0]   set_mask;
  logic [NUM_REGS-1:0]   clr_mask;
  logic [NUM_REGS-1:0]   pending_next;

  // Grant: a lone requester always wins; on contention the one not granted last wins.
  always_comb begin
    alu_ready = reset && alu_valid && (!mem_valid || last_grant);
    mem_ready = reset && mem_valid && (!alu_valid || !last_grant);
    xfer      = alu_ready || mem_ready;
    sel_addr  = mem_ready ? mem_addr : alu_addr;
    sel_data  = mem_ready ? mem_data : alu_data;
  end

  // Scoreboard update: issue sets, transfer clears, set wins; r0 never pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_addr != '0)) set_mask[issue_addr] = 1'b1;
    if (xfer) clr_mask[sel_addr] = 1'b1;
    pending_next    = (pending & ~clr_mask) | set_mask;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_write_enable  <= 1'b0;
      rf_write_address <= '0;
      rf_write_data    <= '0;
      pending          <= '0;
      last_grant       <= 1'b1;
    end else begin
      rf_write_enable <= xfer && (sel_addr != '0);
      pending         <= pending_next;
      if (xfer) begin
        rf_write_address <= sel_addr;
        rf_write_data    <= sel_data;
        last_grant       <= mem_ready;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter: a table of single-cycle
// vectors plus hand sequences for reset behaviour.
module tb_regfile_wb_arbiter;

  logic       clock;
  logic       reset;
  logic       alu_valid, mem_valid, issue_valid;
  logic [2:0] alu_addr, mem_addr, issue_addr;
  logic [7:0] alu_data, mem_data;
  logic       alu_ready, mem_ready;
  logic       rf_write_enable;
  logic [2:0] rf_write_address;
  logic [7:0] rf_write_data;
  logic [7:0] pending;
  logic       last_grant;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
    .rf_write_data(rf_write_data), .pending(pending), .last_grant(last_grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       av; logic [2:0] aa; logic [7:0] ad;
    logic       mv; logic [2:0] ma; logic [7:0] md;
    logic       iv; logic [2:0] ia;
    logic       e_ar, e_mr, e_we;
    logic [2:0] e_wa; logic [7:0] e_wd; logic [7:0] e_pend; logic e_lg;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic av, input logic [2:0] aa, input logic [7:0] ad,
    input logic mv, input logic [2:0] ma, input logic [7:0] md,
    input logic iv, input logic [2:0] ia,
    input logic e_ar, input logic e_mr, input logic e_we,
    input logic [2:0] e_wa, input logic [7:0] e_wd, input logic [7:0] e_pend,
    input logic e_lg);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
    v.iv = iv; v.ia = ia; v.e_ar = e_ar; v.e_mr = e_mr; v.e_we = e_we;
    v.e_wa = e_wa; v.e_wd = e_wd; v.e_pend = e_pend; v.e_lg = e_lg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                       input logic mv, input logic [2:0] ma, input logic [7:0] md,
                       input logic iv, input logic [2:0] ia);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    issue_valid = iv; issue_addr = ia;
  endtask

  task automatic chk_regs(input string tag, input logic we, input logic [2:0] wa,
                          input logic [7:0] wd, input logic [7:0] pend, input logic lg);
    chk({tag, " rf_write_enable"},  32'(rf_write_enable),  32'(we));
    chk({tag, " rf_write_address"}, 32'(rf_write_address), 32'(wa));
    chk({tag, " rf_write_data"},    32'(rf_write_data),    32'(wd));
    chk({tag, " pending"},          32'(pending),          32'(pend));
    chk({tag, " last_grant"},       32'(last_grant),       32'(lg));
  endtask

  initial begin
    // Contention right after reset: ALU, MEM, ALU, MEM.
    vecs[0]  = mk(1,1,8'h11, 1,2,8'h22, 0,0, 1,0, 1,1,8'h11,8'h00,0);
    vecs[1]  = mk(1,1,8'h11, 1,2,8'h22, 0,0, 0,1, 1,2,8'h22,8'h00,1);
    vecs[2]  = mk(1,1,8'h11, 1,2,8'h22, 0,0, 1,0, 1,1,8'h11,8'h00,0);
    vecs[3]  = mk(1,1,8'h11, 1,2,8'h22, 0,0, 0,1, 1,2,8'h22,8'h00,1);
    vecs[4]  = mk(0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 0,2,8'h22,8'h00,1);
    // Single ALU write, pulse lasts one cycle.
    vecs[5]  = mk(1,3,8'h5A, 0,0,8'h00, 0,0, 1,0, 1,3,8'h5A,8'h00,0);
    vecs[6]  = mk(0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 0,3,8'h5A,8'h00,0);
    // MEM to r0: accepted, no write enable.
    vecs[7]  = mk(0,0,8'h00, 1,0,8'hFF, 0,0, 0,1, 0,0,8'hFF,8'h00,1);
    // Lone MEM request with last_grant already MEM.
    vecs[8]  = mk(0,0,8'h00, 1,4,8'h44, 0,0, 0,1, 1,4,8'h44,8'h00,1);
    // Scoreboard: set, set-wins-over-clear, clear (with ignored issue to r0).
    vecs[9]  = mk(0,0,8'h00, 0,0,8'h00, 1,5, 0,0, 0,4,8'h44,8'h20,1);
    vecs[10] = mk(1,5,8'h55, 0,0,8'h00, 1,5, 1,0, 1,5,8'h55,8'h20,0);
    vecs[11] = mk(1,5,8'h66, 0,0,8'h00, 1,0, 1,0, 1,5,8'h66,8'h00,0);
    // Write to a non-pending reg alongside an issue to r7, then contended clear of r7.
    vecs[12] = mk(0,0,8'h00, 1,3,8'h33, 1,7, 0,1, 1,3,8'h33,8'h80,1);
    vecs[13] = mk(1,7,8'h77, 1,6,8'h66, 0,0, 1,0, 1,7,8'h77,8'h00,0);

    // Reset held with both requesters active: no grants, reset values.
    reset = 1'b0;
    drive(1,1,8'h11, 1,2,8'h22, 1,4);
    #1;
    chk("reset alu_ready", 32'(alu_ready), 32'd0);
    chk("reset mem_ready", 32'(mem_ready), 32'd0);
    @(posedge clock); #1;
    chk_regs("reset", 0, 0, 8'h00, 8'h00, 1);
    @(negedge clock);
    drive(0,0,8'h00, 0,0,8'h00, 0,0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md,
            vecs[i].iv, vecs[i].ia);
      #1;
      chk($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
      chk($sformatf("v%0d mem_ready", i), 32'(mem_ready), 32'(vecs[i].e_mr));
      @(posedge clock); #1;
      chk_regs($sformatf("v%0d", i), vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd,
               vecs[i].e_pend, vecs[i].e_lg);
    end

    // Reset asserted just after an ALU accept: captured write is discarded.
    @(negedge clock);
    drive(1,2,8'hA2, 0,0,8'h00, 1,6);
    @(posedge clock); #1;
    chk_regs("pre-reset", 1, 2, 8'hA2, 8'h40, 0);
    #1 reset = 1'b0;
    #1;
    chk("midreset alu_ready", 32'(alu_ready), 32'd0);
    chk_regs("midreset", 0, 0, 8'h00, 8'h00, 1);
    @(posedge clock); #1;
    chk_regs("held reset", 0, 0, 8'h00, 8'h00, 1);
    @(negedge clock);
    drive(0,0,8'h00, 0,0,8'h00, 0,0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_regs("post-release", 0, 0, 8'h00, 8'h00, 1);

    // First contended cycle after reset goes to the ALU.
    @(negedge clock);
    drive(1,1,8'h11, 1,2,8'h22, 0,0);
    #1;
    chk("post-reset alu_ready", 32'(alu_ready), 32'd1);
    chk("post-reset mem_ready", 32'(mem_ready), 32'd0);
    @(posedge clock); #1;
    chk_regs("post-reset grant", 1, 1, 8'h11, 8'h00, 0);
    @(negedge clock);
    drive(0,0,8'h00, 0,0,8'h00, 0,0);
    @(posedge clock); #1;
    chk("post-reset pulse end", 32'(rf_write_enable), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
